fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage with PC register and IF/ID pipeline register; sits directly upstream of control.
//  Issues word requests to instruction memory over a req/ack handshake and holds the fetched word for decode.
//  Presents if_id_opcode (instr[6:0]) to the control unit's opcode input.
//  Supports stall from decode and redirect from branch/jal/jalr resolution.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0013  addi x0,x0,0; value driven on if_id_instr when invalid
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  imem_req      out  1   fetch request; held high with stable imem_addr until imem_ack
//  imem_addr     out  32  word-aligned fetch address (bits [1:0] always 0)
//  imem_ack      in   1   memory accepted request; imem_rdata valid this cycle
//  imem_rdata    in   32  instruction word
//  stall         in   1   decode cannot accept; IF/ID must hold
//  redirect      in   1   taken branch/jal/jalr; flush and refetch
//  redirect_pc   in   32  new PC; bits [1:0] forced to 0
//  if_id_valid   out  1   IF/ID holds a real instruction
//  if_id_pc      out  32  PC of instruction in IF/ID
//  if_id_instr   out  32  instruction in IF/ID (NOP_INSTR when !if_id_valid)
//  if_id_opcode  out  7   if_id_instr[6:0], to control.opcode
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR,
//   skid empty, imem_req=0. Outputs reach these values immediately, not at next edge.
//  FSM states: IDLE, REQ, HOLD, DROP.
//   IDLE: one cycle after reset release, imem_req=0 -> REQ.
//   REQ: imem_req=1, imem_addr=pc. On imem_ack:
//     IF/ID free (!if_id_valid | !stall): load IF/ID {pc,imem_rdata}, valid=1, pc+=4, stay REQ.
//     IF/ID blocked (valid & stall): word to skid {pc,rdata}, pc+=4, -> HOLD.
//   HOLD: imem_req=0. When !stall: skid -> IF/ID, skid empty, -> REQ.
//   DROP: imem_req=1, addr = stale address; on imem_ack discard data -> REQ (pc already = redirect target).
//  Stall without ack: IF/ID, pc hold; REQ keeps req/addr stable. IF/ID valid clears when !stall and no new word.
//  Redirect (highest priority, any state except IDLE): pc<=redirect_pc&~3, if_id_valid<=0, skid emptied;
//   REQ with no ack this cycle -> DROP; REQ with ack this cycle -> data discarded, -> REQ; HOLD -> REQ.
//   Redirect during DROP: pc updated, stay DROP. Redirect overrides stall.
//  Throughput: zero-wait memory (ack same cycle as req) -> one instruction per cycle; first word valid in
//   IF/ID on the edge after first ack (2nd edge after reset release).
//  PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
//  imem_addr never changes while imem_req=1 and imem_ack=0 (request must stay stable).
//  if_id_opcode purely combinational from if_id_instr; invalid slot -> 7'b0010011 so control decodes a NOP.
// STRUCTURE
//  Shared package rv_pkg: opcode constants (R/S/I/L/B/JAL/JALR), NOP_INSTR, fetch FSM state encoding.
//  One sub-module: if_id_reg (IF/ID register with load/hold/flush, async active-low reset).
//  PC register, skid buffer and FSM remain in fetch_stage.
// TESTING
//  Zero-wait mem, ack=req, no stall: words at 0x0,0x4,0x8 -> if_id_pc 0,4,8 on consecutive cycles, valid=1.
//  Ack delayed 3 cycles: imem_addr steady 0x4 while req=1; if_id_valid=0 until ack, then pc=4 loaded.
//  stall=1 for 2 cycles with ack arriving: IF/ID holds pc=0x8, skid gets 0xC; stall=0 -> pc=0xC next.
//  redirect=1, redirect_pc=0x103 mid-wait: data of pending ack discarded, next imem_addr=0x100, IF/ID invalid.
//  PC at 0xFFFF_FFFC fetched -> next imem_addr 0x0000_0000.
//  rst_n low mid-REQ: imem_req, if_id_valid drop immediately; after release first imem_addr=RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32 opcode constants, NOP encoding and fetch FSM states.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_i    = 7'b0010011;
    localparam logic [6:0] c_op_l    = 7'b0000011;
    localparam logic [6:0] c_op_s    = 7'b0100011;
    localparam logic [6:0] c_op_b    = 7'b1100011;
    localparam logic [6:0] c_op_jal  = 7'b1101111;
    localparam logic [6:0] c_op_jalr = 7'b1100111;

    // addi x0,x0,0
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with load, hold and flush.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import rv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    // Invalid slot always presents a NOP so downstream decode stays benign
    assign o_instr = r_valid ? r_instr : NOP_INSTR;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with PC, req/ack memory port, skid buffer
//               and IF/ID register; supports decode stall and redirect.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [6:0]  if_id_opcode
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_drop_addr;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;

    logic        w_skid_load;
    logic        w_skid_clr;
    logic        w_drop_load;
    logic        w_ifid_load;
    logic        w_ifid_flush;
    logic [31:0] w_ifid_pc;
    logic [31:0] w_ifid_instr;
    logic        w_ifid_free;
    logic        w_req;
    logic [31:0] w_addr;

    assign w_ifid_free = !if_id_valid || !stall;

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_skid_load  = 1'b0;
        w_skid_clr   = 1'b0;
        w_drop_load  = 1'b0;
        w_ifid_load  = 1'b0;
        w_ifid_flush = 1'b0;
        w_ifid_pc    = r_pc;
        w_ifid_instr = imem_rdata;
        w_req        = 1'b0;
        w_addr       = r_pc;

        case (r_state)
            FS_IDLE: begin
                w_state_nxt = FS_REQ;
            end

            FS_REQ: begin
                w_req = 1'b1;
                if (redirect) begin
                    w_pc_nxt     = pc_align(redirect_pc);
                    w_ifid_flush = 1'b1;
                    w_skid_clr   = 1'b1;
                    // An outstanding request must still be retired before refetching
                    if (!imem_ack) begin
                        w_state_nxt = FS_DROP;
                        w_drop_load = 1'b1;
                    end
                end else if (imem_ack) begin
                    w_pc_nxt = r_pc + 32'd4;
                    if (w_ifid_free) begin
                        w_ifid_load = 1'b1;
                    end else begin
                        w_skid_load = 1'b1;
                        w_state_nxt = FS_HOLD;
                    end
                end else if (!stall) begin
                    w_ifid_flush = 1'b1;
                end
            end

            FS_HOLD: begin
                if (redirect) begin
                    w_pc_nxt     = pc_align(redirect_pc);
                    w_ifid_flush = 1'b1;
                    w_skid_clr   = 1'b1;
                    w_state_nxt  = FS_REQ;
                end else if (!stall) begin
                    w_ifid_load  = r_skid_valid;
                    w_ifid_pc    = r_skid_pc;
                    w_ifid_instr = r_skid_instr;
                    w_skid_clr   = 1'b1;
                    w_state_nxt  = FS_REQ;
                end
            end

            FS_DROP: begin
                w_req  = 1'b1;
                w_addr = r_drop_addr;
                if (redirect) begin
                    w_pc_nxt     = pc_align(redirect_pc);
                    w_ifid_flush = 1'b1;
                    w_skid_clr   = 1'b1;
                end else if (!stall) begin
                    w_ifid_flush = 1'b1;
                end
                if (imem_ack) begin
                    w_state_nxt = FS_REQ;
                end
            end

            default: begin
                w_state_nxt = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FS_IDLE;
            r_pc         <= RESET_PC;
            r_drop_addr  <= 32'h0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= 32'h0;
            r_skid_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_drop_load) begin
                r_drop_addr <= r_pc;
            end
            if (w_skid_load) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= r_pc;
                r_skid_instr <= imem_rdata;
            end else if (w_skid_clr) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_ifid_load),
        .i_flush (w_ifid_flush),
        .i_pc    (w_ifid_pc),
        .i_instr (w_ifid_instr),
        .o_valid (if_id_valid),
        .o_pc    (if_id_pc),
        .o_instr (if_id_instr)
    );

    assign imem_req     = w_req;
    assign imem_addr    = w_addr;
    assign if_id_opcode = if_id_instr[6:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;

    logic        r_ack_auto;
    logic        r_ack_man;
    int          n_checks;
    int          n_errors;

    localparam logic [31:0] c_nop  = 32'h0000_0013;
    localparam logic [31:0] c_mask = 32'hA5A5_0000;

    // Memory returns a word that encodes its own address
    assign imem_ack   = r_ack_auto ? imem_req : r_ack_man;
    assign imem_rdata = imem_addr ^ c_mask;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (c_nop)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_opcode (if_id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        r_ack_auto  = 1'b1;
        r_ack_man   = 1'b0;
        #3;
        check_eq("rst_req",    {31'h0, imem_req},    32'h0);
        check_eq("rst_valid",  {31'h0, if_id_valid}, 32'h0);
        check_eq("rst_pc",     if_id_pc,             32'h0);
        check_eq("rst_instr",  if_id_instr,          c_nop);
        check_eq("rst_opcode", {25'h0, if_id_opcode}, 32'h13);

        tick();
        tick();
        rst_n = 1'b1;

        // Zero-wait streaming
        tick();
        check_eq("idle_to_req", {31'h0, imem_req},    32'h1);
        check_eq("first_addr",  imem_addr,            32'h0);
        check_eq("first_inval", {31'h0, if_id_valid}, 32'h0);
        tick();
        check_eq("s0_valid", {31'h0, if_id_valid}, 32'h1);
        check_eq("s0_pc",    if_id_pc,             32'h0);
        check_eq("s0_instr", if_id_instr,          32'hA5A5_0000);
        check_eq("s0_addr",  imem_addr,            32'h4);
        tick();
        check_eq("s1_pc", if_id_pc, 32'h4);
        tick();
        check_eq("s2_pc",    if_id_pc,  32'h8);
        check_eq("s2_addr",  imem_addr, 32'hC);

        // Stall with ack arriving: word 0xC goes to skid
        stall = 1'b1;
        tick();
        check_eq("st0_pc",  if_id_pc,             32'h8);
        check_eq("st0_req", {31'h0, imem_req},    32'h0);
        tick();
        check_eq("st1_pc",    if_id_pc,             32'h8);
        check_eq("st1_valid", {31'h0, if_id_valid}, 32'h1);
        stall = 1'b0;
        tick();
        check_eq("skid_pc",    if_id_pc,          32'hC);
        check_eq("skid_instr", if_id_instr,       32'hA5A5_000C);
        check_eq("skid_addr",  imem_addr,         32'h10);
        check_eq("skid_req",   {31'h0, imem_req}, 32'h1);

        // Delayed ack: address must stay put while waiting
        r_ack_auto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("wait_addr",  imem_addr,            32'h10);
            check_eq("wait_req",   {31'h0, imem_req},    32'h1);
            check_eq("wait_valid", {31'h0, if_id_valid}, 32'h0);
        end
        r_ack_man = 1'b1;
        tick();
        r_ack_man = 1'b0;
        check_eq("dly_valid", {31'h0, if_id_valid}, 32'h1);
        check_eq("dly_pc",    if_id_pc,             32'h10);
        check_eq("dly_addr",  imem_addr,            32'h14);
        tick();
        check_eq("dly_drain", {31'h0, if_id_valid}, 32'h0);
        check_eq("dly_addr2", imem_addr,            32'h14);

        // Redirect while a request is pending
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check_eq("drop_req",   {31'h0, imem_req},    32'h1);
        check_eq("drop_addr",  imem_addr,            32'h14);
        check_eq("drop_valid", {31'h0, if_id_valid}, 32'h0);
        r_ack_man = 1'b1;
        tick();
        r_ack_man = 1'b0;
        check_eq("rdr_addr",   imem_addr,            32'h100);
        check_eq("rdr_valid",  {31'h0, if_id_valid}, 32'h0);
        check_eq("rdr_opcode", {25'h0, if_id_opcode}, 32'h13);
        r_ack_auto = 1'b1;
        tick();
        check_eq("rdr_pc",    if_id_pc,             32'h100);
        check_eq("rdr_vld",   {31'h0, if_id_valid}, 32'h1);

        // Redirect with same-cycle ack, then PC wrap-around
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        check_eq("wrap_flush", {31'h0, if_id_valid}, 32'h0);
        check_eq("wrap_addr",  imem_addr,            32'hFFFF_FFFC);
        tick();
        check_eq("wrap_pc",    if_id_pc,  32'hFFFF_FFFC);
        check_eq("wrap_next",  imem_addr, 32'h0);
        tick();
        check_eq("wrap_pc0",   if_id_pc,  32'h0);

        // Asynchronous reset while a request is outstanding
        r_ack_auto = 1'b0;
        tick();
        check_eq("pre_rst_req", {31'h0, imem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_req",   {31'h0, imem_req},    32'h0);
        check_eq("arst_valid", {31'h0, if_id_valid}, 32'h0);
        check_eq("arst_instr", if_id_instr,          c_nop);
        tick();
        rst_n      = 1'b1;
        r_ack_auto = 1'b1;
        tick();
        check_eq("post_rst_addr", imem_addr,         32'h0);
        check_eq("post_rst_req",  {31'h0, imem_req}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
